mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter and sequencer placed between the CPU core and the SoC's single memory. It shares one memory port between the instruction-fetch port and the load/store data port, sequences each access through a registered request/acknowledge handshake, and aborts accesses that exceed a timeout. Grant is round-robin so neither port starves.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; must be a multiple of 8
- TIMEOUT, 255, cycles in BUSY before abort; 0 disables; max 65535

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  DATA_WIDTH  fetch read data, valid while i_ack=1
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  fetch timed out; valid while i_ack=1
- d_req  in  1  data request; held with d_* inputs until d_ack
- d_we  in  1  1 = write, 0 = read
- d_wstrb  in  DATA_WIDTH/8  byte write enables
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_rdata  out  DATA_WIDTH  read data, valid while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  data access timed out; valid while d_ack=1
- m_req  out  1  memory request, held until m_ack or timeout
- m_we, m_wstrb, m_addr, m_wdata  out  1, DATA_WIDTH/8, ADDR_WIDTH, DATA_WIDTH  registered copy of the granted request
- m_rdata  in  DATA_WIDTH  memory read data, valid with m_ack
- m_ack  in  1  memory completion, one cycle; may coincide with the first m_req cycle

## Operation
- FSM states: IDLE, BUSY, RESP. Reset enters IDLE.
- IDLE: when any request is high, pick a winner and latch its fields into m_*. Fetch drives m_we=0 and m_wstrb=0. Set m_req=1, clear the timeout counter, go to BUSY. Hold m_req=0 while no request is high.
- Arbitration: with only one request high, that port wins. With both high, the port not recorded in last_grant wins. last_grant updates on every grant and resets to DATA, so the first tie after reset goes to fetch.
- BUSY: m_req=1 and m_* stable. The counter increments each cycle.
  - On m_ack: latch m_rdata into the granted port's rdata, drop m_req, go to RESP with err=0.
  - When the counter reaches TIMEOUT with no m_ack: drop m_req, set rdata=0 and err=1, go to RESP.
  - m_ack and timeout in the same cycle: m_ack wins and err=0.
- RESP: pulse the granted port's ack for exactly one cycle, then go to IDLE. The other port's ack and err stay 0.
- Requesters deassert req, or present a new request, after seeing ack. Requests are not sampled in BUSY or RESP, so a request held through ack is not double-issued.
- The counter is 16 bits and saturates. With TIMEOUT=0 the block never aborts.
- Reset mid-transaction: all outputs clear immediately, no ack is issued, the in-flight access is lost, and the requester must reissue.

## Timing
- Reset values: m_req, m_we, m_wstrb, m_addr, m_wdata, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata all 0. State IDLE, last_grant=DATA, counter 0.
- The req edge in cycle 0 (IDLE) gives m_req=1 in cycle 1.
- An m_ack in cycle k gives x_ack=1 in cycle k+1 and IDLE in cycle k+2.
- Minimum latency from req to ack is 2 cycles (m_ack in the first BUSY cycle).
- Peak throughput is one access per 3 cycles.
- Timeout abort: with m_req first high in cycle 1, the last BUSY cycle is cycle TIMEOUT and err/ack are asserted in cycle TIMEOUT+1.
- rdata and err hold their value after the ack cycle until the next completion on that port.

## Test plan
- Fetch only, memory acks in first BUSY cycle, i_addr=0x10, m_rdata=0x00200293. Required: m_req in cycle 1 with m_addr=0x10 and m_we=0; i_ack and i_rdata=0x00200293 in cycle 2; d_ack stays 0.
- Data write, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, memory ack after 3 cycles. Required: m_* match the inputs for all BUSY cycles; one d_ack pulse; d_err=0.
- Both requests high from reset, each port held until its ack then re-raised. Required: grants go fetch, data, fetch, data; no back-to-back repeat while both are pending.
- TIMEOUT=4, memory never acks. Required: m_req high for exactly 4 cycles; i_ack=1, i_err=1, i_rdata=0 in the next cycle; the next request proceeds normally.
- TIMEOUT=4, m_ack in the 4th BUSY cycle. Required: err=0 and rdata=m_rdata.
- reset_n pulsed low during BUSY. Required: m_req and all acks clear asynchronously; after release, IDLE with last_grant=DATA and no spurious ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch and
// load/store ports. Round-robin grant, registered req/ack sequencing and a
// BUSY timeout that aborts accesses the memory never acknowledges.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,

    // instruction-fetch port
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_ack,
    output logic                      i_err,

    // load/store port
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_ack,
    output logic                      d_err,

    // shared memory port
    output logic                      m_req,
    output logic                      m_we,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic                      m_ack
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = 16;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    // Counter value seen in the last BUSY cycle before an abort; the counter
    // is cleared on grant, so the TIMEOUT-th BUSY cycle holds TIMEOUT-1.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
        (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    // Payload presented on the memory port for the granted access
    typedef struct packed {
        logic                  we;
        logic [STRB_WIDTH-1:0] wstrb;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mreq_t;

    state_t                 state_q, state_d;
    port_t                  last_grant_q, last_grant_d;
    port_t                  grant_q, grant_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   m_req_q, m_req_d;
    mreq_t                  mreq_q, mreq_d;
    logic [DATA_WIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic                   i_err_q, i_err_d;
    logic                   d_err_q, d_err_d;
    logic                   i_ack_q, i_ack_d;
    logic                   d_ack_q, d_ack_d;

    logic                   pick_data;
    logic                   timeout_hit;

    // Next-state, arbitration and response logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        m_req_d      = m_req_q;
        mreq_d       = mreq_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_err_d      = i_err_q;
        d_err_d      = d_err_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;

        // Data wins when alone, or on a tie when fetch was granted last
        pick_data   = d_req && (!i_req || (last_grant_q == PORT_FETCH));
        timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

        case (state_q)
            IDLE: begin
                m_req_d = 1'b0;
                if (i_req || d_req) begin
                    if (pick_data) begin
                        grant_d      = PORT_DATA;
                        last_grant_d = PORT_DATA;
                        mreq_d       = '{we: d_we, wstrb: d_wstrb,
                                         addr: d_addr, wdata: d_wdata};
                    end else begin
                        grant_d      = PORT_FETCH;
                        last_grant_d = PORT_FETCH;
                        mreq_d       = '{we: 1'b0, wstrb: '0,
                                         addr: i_addr, wdata: '0};
                    end
                    m_req_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                // m_ack takes priority over a coincident timeout
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (grant_q == PORT_DATA) begin
                        d_rdata_d = m_rdata;
                        d_err_d   = 1'b0;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_err_d   = 1'b0;
                        i_ack_d   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    m_req_d = 1'b0;
                    state_d = RESP;
                    if (grant_q == PORT_DATA) begin
                        d_rdata_d = '0;
                        d_err_d   = 1'b1;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_err_d   = 1'b1;
                        i_ack_d   = 1'b1;
                    end
                end
            end

            RESP: begin
                // ack is high for this single cycle only
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DATA;
            grant_q      <= PORT_FETCH;
            cnt_q        <= '0;
            m_req_q      <= 1'b0;
            mreq_q       <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            m_req_q      <= m_req_d;
            mreq_q       <= mreq_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = mreq_q.we;
    assign m_wstrb = mreq_q.wstrb;
    assign m_addr  = mreq_q.addr;
    assign m_wdata = mreq_q.wdata;
    assign i_rdata = i_rdata_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-port accesses plus
// hand-written tie-arbitration and mid-transaction reset sequences.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk;
    logic          reset_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_wstrb;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          d_err;
    logic          m_req;
    logic          m_we;
    logic [3:0]    m_wstrb;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_wstrb (d_wstrb),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_wstrb (m_wstrb),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          port;   // 0 fetch, 1 data
        logic          we;
        logic [3:0]    wstrb;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   mrdata; // memory read data
        int            delay;  // BUSY cycle carrying m_ack, 0 = never
        logic          err;    // expected
        logic [31:0]   rdata;  // expected
        int            lat;    // expected req-to-ack cycles
    } vec_t;

    vec_t  vecs [8];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    ack_delay = 0;
    int    bcnt = 0;
    logic [31:0] exp_i_rdata = '0;
    logic [31:0] exp_d_rdata = '0;
    logic        exp_i_err = 1'b0;
    logic        exp_d_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge, then update the memory model
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_req) begin
            bcnt++;
            m_ack = (ack_delay != 0) && (bcnt == ack_delay);
        end else begin
            bcnt  = 0;
            m_ack = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit   seen;
        bit   other;
        bit   payload_ok;
        int   lat;
        int   mreq_cycles;
        logic own_ack;
        logic oth_ack;
        ack_delay = v.delay;
        m_rdata   = v.mrdata;
        i_req     = !v.port;
        i_addr    = v.addr;
        d_req     = v.port;
        d_we      = v.we;
        d_wstrb   = v.wstrb;
        d_addr    = v.addr;
        d_wdata   = v.wdata;
        seen = 0; other = 0; payload_ok = 1; lat = 0; mreq_cycles = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            own_ack = v.port ? d_ack : i_ack;
            oth_ack = v.port ? i_ack : d_ack;
            if (m_req) begin
                mreq_cycles++;
                if (m_addr !== v.addr) payload_ok = 0;
                if (m_we !== (v.port ? v.we : 1'b0)) payload_ok = 0;
                if (m_wstrb !== (v.port ? v.wstrb : 4'b0000)) payload_ok = 0;
                if (v.port && (m_wdata !== v.wdata)) payload_ok = 0;
            end
            if (oth_ack) other = 1;
            if (own_ack) begin
                seen = 1;
                lat  = c;
            end
        end
        chk($sformatf("v%0d_ack_seen", idx), 32'(seen), 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_mreq_cycles", idx), 32'(mreq_cycles), 32'(v.lat - 1));
        chk($sformatf("v%0d_payload", idx), 32'(payload_ok), 32'd1);
        chk($sformatf("v%0d_other_ack", idx), 32'(other), 32'd0);
        if (v.port) begin
            exp_d_rdata = v.rdata;
            exp_d_err   = v.err;
        end else begin
            exp_i_rdata = v.rdata;
            exp_i_err   = v.err;
        end
        chk($sformatf("v%0d_i_rdata", idx), i_rdata, exp_i_rdata);
        chk($sformatf("v%0d_d_rdata", idx), d_rdata, exp_d_rdata);
        chk($sformatf("v%0d_errs", idx), 32'({i_err, d_err}), 32'({exp_i_err, exp_d_err}));
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk($sformatf("v%0d_ack_pulse", idx), 32'({i_ack, d_ack}), 32'd0);
        chk($sformatf("v%0d_hold_rdata", idx), v.port ? d_rdata : i_rdata, v.rdata);
    endtask

    // Both ports request continuously; returns the first n granted ports in order
    task automatic tie_run(input int n, output int got [4], output int cycles);
        int k;
        k = 0;
        cycles = 0;
        for (int j = 0; j < 4; j++) got[j] = 9;
        i_addr = 32'h40; d_addr = 32'h80; d_we = 1'b0; d_wstrb = 4'h0; d_wdata = '0;
        ack_delay = 1;
        m_rdata = 32'h0000_5555;
        i_req = 1'b1;
        d_req = 1'b1;
        for (int c = 1; c <= 60 && k < n; c++) begin
            tick();
            if (i_ack && k < 4) begin got[k] = 0; k++; end
            if (d_ack && k < 4) begin got[k] = 1; k++; end
            if (k >= n) begin
                i_req  = 1'b0;
                d_req  = 1'b0;
                cycles = c;
            end
        end
        chk("tie_completed", 32'(k), 32'(n));
        tick();
        tick();
    endtask

    initial begin
        int got [4];
        int cycles;
        bit spurious;

        //          port we  wstrb    addr          wdata          mrdata         dly err rdata          lat
        vecs[0] = '{1'b0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         32'h0020_0293, 1, 1'b0, 32'h0020_0293, 2};
        vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1'b0, 32'h1234_5678, 4};
        vecs[2] = '{1'b0, 1'b0, 4'b0000, 32'h0000_0020, 32'h0,         32'h1111_1111, 0, 1'b1, 32'h0,         5};
        vecs[3] = '{1'b0, 1'b0, 4'b0000, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 32'hCAFE_F00D, 3};
        vecs[4] = '{1'b0, 1'b0, 4'b0000, 32'h0000_0018, 32'h0,         32'hA5A5_A5A5, 4, 1'b0, 32'hA5A5_A5A5, 5};
        vecs[5] = '{1'b1, 1'b0, 4'b0000, 32'h0000_0200, 32'h0,         32'h2222_2222, 0, 1'b1, 32'h0,         5};
        vecs[6] = '{1'b1, 1'b0, 4'b0000, 32'h0000_0204, 32'h0,         32'h5A5A_0001, 4, 1'b0, 32'h5A5A_0001, 5};
        vecs[7] = '{1'b1, 1'b1, 4'b1100, 32'h0000_0208, 32'h0000_ABCD, 32'h0000_0077, 1, 1'b0, 32'h0000_0077, 2};

        reset_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_ack = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset values
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_ctl", 32'({m_we, m_wstrb}), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_acks_errs", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Ties alternate fetch, data, fetch, data at one access per 3 cycles
        tie_run(4, got, cycles);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("tie_grant%0d", j), 32'(got[j]), 32'(j % 2));
        end
        chk("tie_throughput", 32'(cycles), 32'd11);

        // Fetch grant (last_grant becomes fetch), then reset while BUSY
        ack_delay = 0;
        i_addr = 32'h60;
        i_req = 1'b1;
        tick();
        tick();
        chk("pre_rst_m_req", 32'(m_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_m_req", 32'(m_req), 32'd0);
        chk("async_rst_acks", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
        chk("async_rst_m_addr", m_addr, 32'd0);
        i_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (i_ack || d_ack || m_req) spurious = 1;
        end
        chk("post_rst_quiet", 32'(spurious), 32'd0);

        // First tie after reset must go to fetch again
        tie_run(1, got, cycles);
        chk("post_rst_tie_grant", 32'(got[0]), 32'd0);
        chk("post_rst_tie_latency", 32'(cycles), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
